// File: rtl/dqn_target_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dqn_target_update_scheduler
// Description : Interleaves target-network soft updates with main-network
//               training. Counts training steps and, every UPDATE_PERIOD
//               steps or on a forced request, withholds the training grant,
//               pulses an update request and waits for the update to finish.
// Revision    : 1.0 - initial release
// ============================================================================
module dqn_target_update_scheduler #(
    parameter int UPDATE_PERIOD      = 100,
    parameter int STEP_COUNTER_WIDTH = 16,
    parameter int TIMEOUT_CYCLES     = 8192
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_enable,
    input  logic                          i_train_start,
    input  logic                          i_train_step_done,
    input  logic                          i_force_update,
    input  logic                          i_update_done,
    output logic                          o_train_grant,
    output logic                          o_update_request,
    output logic                          o_update_busy,
    output logic [STEP_COUNTER_WIDTH-1:0] o_step_count,
    output logic [STEP_COUNTER_WIDTH-1:0] o_update_count,
    output logic                          o_timeout_error
);

    localparam int TIMER_W = 16;
    localparam logic [STEP_COUNTER_WIDTH-1:0] C_LAST_STEP =
        STEP_COUNTER_WIDTH'(UPDATE_PERIOD - 1);
    localparam logic [TIMER_W-1:0] C_TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRAIN     = 3'd1,
        ST_REQ       = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_ERROR     = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_in_flight;
    logic                 r_pending;
    logic                 w_pending_set;
    logic                 w_pending_next;
    logic [TIMER_W-1:0]   r_timer;
    logic                 w_step_last;

    assign w_step_last = (o_step_count == C_LAST_STEP);

    // Next-state decode and the pending-update flag's next value.
    always_comb begin
        w_next_state  = r_state;
        w_pending_set = 1'b0;
        if (r_state == ST_TRAIN) begin
            w_pending_set = i_force_update | (i_train_step_done & w_step_last);
        end
        case (r_state)
            ST_IDLE: begin
                if (i_enable) w_next_state = ST_TRAIN;
            end
            ST_TRAIN: begin
                if (!i_enable && !r_in_flight) begin
                    w_next_state = ST_IDLE;
                end else if (r_pending && !r_in_flight && !i_train_start) begin
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                w_next_state = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // A done arriving on the timeout cycle still counts as success.
                if (i_update_done) begin
                    w_next_state = i_enable ? ST_TRAIN : ST_IDLE;
                end else if (r_timer == C_TIMEOUT_LAST) begin
                    w_next_state = ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (!i_enable) w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        if (r_state == ST_REQ) begin
            w_pending_next = 1'b0;
        end else begin
            w_pending_next = r_pending | w_pending_set;
        end
    end

    // State, bookkeeping and registered outputs (derived from next state so
    // they line up with the state they describe).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_in_flight      <= 1'b0;
            r_pending        <= 1'b0;
            r_timer          <= '0;
            o_train_grant    <= 1'b0;
            o_update_request <= 1'b0;
            o_update_busy    <= 1'b0;
            o_step_count     <= '0;
            o_update_count   <= '0;
            o_timeout_error  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_pending <= w_pending_next;

            // A start in the same cycle as a done keeps the new step in flight.
            if (i_train_start && o_train_grant) begin
                r_in_flight <= 1'b1;
            end else if (i_train_step_done) begin
                r_in_flight <= 1'b0;
            end

            if (r_state == ST_TRAIN && i_train_step_done) begin
                o_step_count <= w_step_last ? '0 : o_step_count + 1'b1;
            end

            if (r_state == ST_WAIT_DONE) begin
                r_timer <= r_timer + 1'b1;
            end else begin
                r_timer <= '0;
            end

            if (r_state == ST_WAIT_DONE && i_update_done) begin
                o_update_count <= o_update_count + 1'b1;
            end

            if (r_state == ST_WAIT_DONE && w_next_state == ST_ERROR) begin
                o_timeout_error <= 1'b1;
            end else if (r_state == ST_ERROR && w_next_state == ST_IDLE) begin
                o_timeout_error <= 1'b0;
            end

            o_train_grant    <= (w_next_state == ST_TRAIN) && !w_pending_next;
            o_update_request <= (w_next_state == ST_REQ);
            o_update_busy    <= (w_next_state == ST_REQ) || (w_next_state == ST_WAIT_DONE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dqn_target_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dqn_target_update_scheduler
// Description : Directed self-checking bench for the target-update scheduler
//               (UPDATE_PERIOD=3, default timeout of 8192 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dqn_target_update_scheduler;

    localparam int SCW = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic           train_start = 1'b0;
    logic           train_step_done = 1'b0;
    logic           force_update = 1'b0;
    logic           update_done = 1'b0;
    logic           train_grant;
    logic           update_request;
    logic           update_busy;
    logic [SCW-1:0] step_count;
    logic [SCW-1:0] update_count;
    logic           timeout_error;

    int n_checks = 0;
    int n_fail   = 0;

    dqn_target_update_scheduler #(
        .UPDATE_PERIOD      (3),
        .STEP_COUNTER_WIDTH (SCW),
        .TIMEOUT_CYCLES     (8192)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_enable          (enable),
        .i_train_start     (train_start),
        .i_train_step_done (train_step_done),
        .i_force_update    (force_update),
        .i_update_done     (update_done),
        .o_train_grant     (train_grant),
        .o_update_request  (update_request),
        .o_update_busy     (update_busy),
        .o_step_count      (step_count),
        .o_update_count    (update_count),
        .o_timeout_error   (timeout_error)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Advance one cycle; outputs are then stable for the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One granted start followed by its done pulse on the next cycle.
    task automatic run_step();
        train_start = 1'b1;
        tick();
        train_start = 1'b0;
        train_step_done = 1'b1;
        tick();
        train_step_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0; train_start = 1'b0; train_step_done = 1'b0;
        force_update = 1'b0; update_done = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (train_grant !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %b expected 0", train_grant); end
        n_checks++; if (update_request !== 1'b0) begin n_fail++; $display("FAIL reset_request: got %b expected 0", update_request); end
        n_checks++; if (update_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", update_busy); end
        n_checks++; if (step_count !== 16'd0) begin n_fail++; $display("FAIL reset_step_count: got %0d expected 0", step_count); end
        n_checks++; if (update_count !== 16'd0) begin n_fail++; $display("FAIL reset_update_count: got %0d expected 0", update_count); end
        n_checks++; if (timeout_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", timeout_error); end
    endtask

    task automatic test_periodic();
        enable = 1'b1;
        tick();
        n_checks++; if (train_grant !== 1'b1) begin n_fail++; $display("FAIL periodic_grant_on: got %b expected 1", train_grant); end
        run_step();
        run_step();
        n_checks++; if (step_count !== 16'd2) begin n_fail++; $display("FAIL periodic_step2: got %0d expected 2", step_count); end
        run_step();
        // Cycle t+1 after the third done: pending set, grant withdrawn.
        n_checks++; if (step_count !== 16'd0) begin n_fail++; $display("FAIL periodic_step_wrap: got %0d expected 0", step_count); end
        n_checks++; if (train_grant !== 1'b0) begin n_fail++; $display("FAIL periodic_grant_t1: got %b expected 0", train_grant); end
        n_checks++; if (update_request !== 1'b0) begin n_fail++; $display("FAIL periodic_req_t1: got %b expected 0", update_request); end
        tick();
        n_checks++; if (update_request !== 1'b1) begin n_fail++; $display("FAIL periodic_req_t2: got %b expected 1", update_request); end
        n_checks++; if (update_busy !== 1'b1) begin n_fail++; $display("FAIL periodic_busy_t2: got %b expected 1", update_busy); end
        tick();
        n_checks++; if (update_request !== 1'b0) begin n_fail++; $display("FAIL periodic_req_one_cycle: got %b expected 0", update_request); end
        n_checks++; if (update_busy !== 1'b1) begin n_fail++; $display("FAIL periodic_busy_wait: got %b expected 1", update_busy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (train_grant !== 1'b0) begin n_fail++; $display("FAIL periodic_grant_wait: got %b expected 0", train_grant); end
        end
        update_done = 1'b1;
        tick();
        update_done = 1'b0;
        n_checks++; if (train_grant !== 1'b1) begin n_fail++; $display("FAIL periodic_grant_after: got %b expected 1", train_grant); end
        n_checks++; if (update_busy !== 1'b0) begin n_fail++; $display("FAIL periodic_busy_after: got %b expected 0", update_busy); end
        n_checks++; if (update_count !== 16'd1) begin n_fail++; $display("FAIL periodic_update_count: got %0d expected 1", update_count); end
        n_checks++; if (step_count !== 16'd0) begin n_fail++; $display("FAIL periodic_step_after: got %0d expected 0", step_count); end
    endtask

    task automatic test_force_inflight();
        train_start = 1'b1;
        tick();
        train_start = 1'b0;
        force_update = 1'b1;
        tick();
        force_update = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (update_request !== 1'b0) begin n_fail++; $display("FAIL force_req_early: got %b expected 0", update_request); end
            n_checks++; if (train_grant !== 1'b0) begin n_fail++; $display("FAIL force_grant_hold: got %b expected 0", train_grant); end
            tick();
        end
        train_step_done = 1'b1;
        tick();
        train_step_done = 1'b0;
        n_checks++; if (update_request !== 1'b0) begin n_fail++; $display("FAIL force_req_d1: got %b expected 0", update_request); end
        n_checks++; if (train_grant !== 1'b0) begin n_fail++; $display("FAIL force_grant_d1: got %b expected 0", train_grant); end
        tick();
        n_checks++; if (update_request !== 1'b1) begin n_fail++; $display("FAIL force_req_d2: got %b expected 1", update_request); end
        n_checks++; if (step_count !== 16'd1) begin n_fail++; $display("FAIL force_step_count: got %0d expected 1", step_count); end
        tick();
        update_done = 1'b1;
        tick();
        update_done = 1'b0;
        n_checks++; if (train_grant !== 1'b1) begin n_fail++; $display("FAIL force_grant_after: got %b expected 1", train_grant); end
        n_checks++; if (update_count !== 16'd2) begin n_fail++; $display("FAIL force_update_count: got %0d expected 2", update_count); end
    endtask

    task automatic test_same_cycle();
        train_start = 1'b1;
        tick();
        train_step_done = 1'b1;
        tick();
        train_start = 1'b0;
        train_step_done = 1'b0;
        n_checks++; if (step_count !== 16'd2) begin n_fail++; $display("FAIL same_step_once: got %0d expected 2", step_count); end
        // Still in flight, so a disable must not drop the scheduler to idle.
        enable = 1'b0;
        tick();
        n_checks++; if (train_grant !== 1'b1) begin n_fail++; $display("FAIL same_inflight_held: got %b expected 1", train_grant); end
        enable = 1'b1;
        train_step_done = 1'b1;
        tick();
        train_step_done = 1'b0;
        n_checks++; if (step_count !== 16'd0) begin n_fail++; $display("FAIL same_step_wrap: got %0d expected 0", step_count); end
        tick();
        n_checks++; if (update_request !== 1'b1) begin n_fail++; $display("FAIL same_req: got %b expected 1", update_request); end
        tick();
        update_done = 1'b1;
        tick();
        update_done = 1'b0;
        n_checks++; if (update_count !== 16'd3) begin n_fail++; $display("FAIL same_update_count: got %0d expected 3", update_count); end
    endtask

    task automatic test_timeout();
        force_update = 1'b1;
        tick();
        force_update = 1'b0;
        tick();
        n_checks++; if (update_request !== 1'b1) begin n_fail++; $display("FAIL timeout_req: got %b expected 1", update_request); end
        for (int i = 0; i < 8192; i++) tick();
        n_checks++; if (timeout_error !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0", timeout_error); end
        n_checks++; if (update_busy !== 1'b1) begin n_fail++; $display("FAIL timeout_busy_last: got %b expected 1", update_busy); end
        tick();
        n_checks++; if (timeout_error !== 1'b1) begin n_fail++; $display("FAIL timeout_error_set: got %b expected 1", timeout_error); end
        n_checks++; if (train_grant !== 1'b0) begin n_fail++; $display("FAIL timeout_grant: got %b expected 0", train_grant); end
        n_checks++; if (update_busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b expected 0", update_busy); end
        update_done = 1'b1;
        tick();
        update_done = 1'b0;
        n_checks++; if (timeout_error !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b expected 1", timeout_error); end
        n_checks++; if (update_count !== 16'd3) begin n_fail++; $display("FAIL timeout_late_done: got %0d expected 3", update_count); end
        enable = 1'b0;
        tick();
        n_checks++; if (timeout_error !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b expected 0", timeout_error); end
        enable = 1'b1;
        tick();
        n_checks++; if (train_grant !== 1'b1) begin n_fail++; $display("FAIL timeout_recover: got %b expected 1", train_grant); end
    endtask

    task automatic test_disable_wait();
        force_update = 1'b1;
        tick();
        force_update = 1'b0;
        tick();
        tick();
        enable = 1'b0;
        tick();
        n_checks++; if (update_busy !== 1'b1) begin n_fail++; $display("FAIL disable_deferred: got %b expected 1", update_busy); end
        update_done = 1'b1;
        tick();
        update_done = 1'b0;
        n_checks++; if (update_busy !== 1'b0) begin n_fail++; $display("FAIL disable_busy: got %b expected 0", update_busy); end
        n_checks++; if (train_grant !== 1'b0) begin n_fail++; $display("FAIL disable_idle_grant: got %b expected 0", train_grant); end
        n_checks++; if (update_count !== 16'd4) begin n_fail++; $display("FAIL disable_update_count: got %0d expected 4", update_count); end
        enable = 1'b1;
        tick();
        n_checks++; if (train_grant !== 1'b1) begin n_fail++; $display("FAIL disable_reenable: got %b expected 1", train_grant); end
    endtask

    task automatic test_reset_midop();
        force_update = 1'b1;
        tick();
        force_update = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if (update_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", update_busy); end
        n_checks++; if (update_count !== 16'd0) begin n_fail++; $display("FAIL midrst_update_count: got %0d expected 0", update_count); end
        n_checks++; if (train_grant !== 1'b0) begin n_fail++; $display("FAIL midrst_grant: got %b expected 0", train_grant); end
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (train_grant !== 1'b1) begin n_fail++; $display("FAIL midrst_grant_after: got %b expected 1", train_grant); end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++; if (update_request !== 1'b0) begin n_fail++; $display("FAIL midrst_no_reissue: got %b expected 0", update_request); end
        end
        n_checks++; if (update_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_after: got %b expected 0", update_busy); end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_force_inflight();
        test_same_cycle();
        test_timeout();
        test_disable_wait();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
